ram_port_arbiter: RTL

- Shares the single sram misc/CPU access port between three requesters:
  - ioctl download writes: buffered, cannot be stalled.
  - wd1793 track-buffer reads.
  - Z80 memory cycles.
- Sits between the SamCoupe top and sram. Produces cpu_busy, which is ORed into the cpu_en wait term alongside ram_wait/io_wait.
- Uses fixed priority with a CPU anti-starvation rule and a per-transaction timeout.

---
 rtl/ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Shares the single SRAM misc/CPU port between ioctl download writes (FIFO-buffered),
// wd1793 track-buffer reads and Z80 memory cycles, with CPU anti-starvation and timeout.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT   = 63,
    parameter int unsigned MAX_BURST = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_busy,
    input  logic              fdd_req,
    input  logic [ADDR_W-1:0] fdd_addr,
    output logic [7:0]        fdd_dout,
    output logic              fdd_ack,
    input  logic              misc_wr,
    input  logic [ADDR_W-1:0] misc_addr,
    input  logic [7:0]        misc_din,
    output logic              misc_full,
    output logic              misc_ovf,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              err
);

    localparam int unsigned PTR_W   = $clog2(DEPTH) + 1;
    localparam int unsigned IDX_W   = PTR_W - 1;
    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    typedef enum logic [1:0] {GntNone, GntCpu, GntFdd, GntMisc} grant_e;

    state_e              state_q, state_d;
    grant_e              grant_q, grant_d;
    logic                cpu_req_q;
    logic                cpu_pend_q;
    logic                cpu_we_q;
    logic [ADDR_W-1:0]   cpu_addr_q;
    logic [7:0]          cpu_din_q;
    logic                fdd_pend_q;
    logic [ADDR_W-1:0]   fdd_addr_q;
    logic [ADDR_W-1:0]   fifo_addr_q [DEPTH];
    logic [7:0]          fifo_data_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic                mem_wsel_q, mem_wsel_d;
    logic [7:0]          cpu_dout_q;
    logic [7:0]          fdd_dout_q;
    logic                fdd_ack_q;
    logic                misc_ovf_q;
    logic                err_q;

    logic cpu_rise;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic complete;
    logic abort;

    assign cpu_rise   = cpu_req & ~cpu_req_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push       = misc_wr & ~fifo_full;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        burst_d    = cpu_pend_q ? burst_q : '0;
        timer_d    = timer_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wsel_d = mem_wsel_q;
        pop        = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state_q)
            StIdle: begin
                // Forced CPU slot once MAX_BURST other grants went by while it waited.
                if (cpu_pend_q && burst_q == BURST_W'(MAX_BURST)) grant_d = GntCpu;
                else if (!fifo_empty)                             grant_d = GntMisc;
                else if (fdd_pend_q)                              grant_d = GntFdd;
                else if (cpu_pend_q)                              grant_d = GntCpu;
                else                                              grant_d = GntNone;
                case (grant_d)
                    GntCpu: begin
                        mem_addr_d = cpu_addr_q;
                        mem_din_d  = cpu_din_q;
                        mem_wsel_d = cpu_we_q;
                        burst_d    = '0;
                    end
                    GntMisc: begin
                        mem_addr_d = fifo_addr_q[rd_ptr_q[IDX_W-1:0]];
                        mem_din_d  = fifo_data_q[rd_ptr_q[IDX_W-1:0]];
                        mem_wsel_d = 1'b1;
                        pop        = 1'b1;
                        if (cpu_pend_q) burst_d = burst_q + BURST_W'(1);
                    end
                    GntFdd: begin
                        mem_addr_d = fdd_addr_q;
                        mem_din_d  = '0;
                        mem_wsel_d = 1'b0;
                        if (cpu_pend_q) burst_d = burst_q + BURST_W'(1);
                    end
                    default: ;
                endcase
                if (grant_d != GntNone) state_d = StIssue;
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (mem_ready) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= GntNone;
            cpu_req_q  <= 1'b0;
            cpu_pend_q <= 1'b0;
            cpu_we_q   <= 1'b0;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
            fdd_pend_q <= 1'b0;
            fdd_addr_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            burst_q    <= '0;
            timer_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wsel_q <= 1'b0;
            cpu_dout_q <= 8'hFF;
            fdd_dout_q <= '0;
            fdd_ack_q  <= 1'b0;
            misc_ovf_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            burst_q    <= burst_d;
            timer_q    <= timer_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wsel_q <= mem_wsel_d;
            cpu_req_q  <= cpu_req;

            if (cpu_rise) begin
                cpu_pend_q <= 1'b1;
                cpu_we_q   <= cpu_we;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end else if ((complete || abort) && grant_q == GntCpu) begin
                cpu_pend_q <= 1'b0;
            end

            if (fdd_req) begin
                fdd_pend_q <= 1'b1;
                fdd_addr_q <= fdd_addr;
            end else if ((complete || abort) && grant_q == GntFdd) begin
                fdd_pend_q <= 1'b0;
            end

            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (misc_wr && fifo_full) misc_ovf_q <= 1'b1;

            if (grant_q == GntCpu && !mem_wsel_q) begin
                if (complete)   cpu_dout_q <= mem_dout;
                else if (abort) cpu_dout_q <= 8'hFF;
            end

            fdd_ack_q <= (complete || abort) && grant_q == GntFdd;
            if (grant_q == GntFdd) begin
                if (complete)   fdd_dout_q <= mem_dout;
                else if (abort) fdd_dout_q <= 8'hFF;
            end

            if (abort) err_q <= 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[IDX_W-1:0]] <= misc_addr;
            fifo_data_q[wr_ptr_q[IDX_W-1:0]] <= misc_din;
        end
    end

    assign cpu_busy  = cpu_pend_q | (grant_q == GntCpu && state_q != StIdle) | cpu_rise;
    assign cpu_dout  = cpu_dout_q;
    assign fdd_dout  = fdd_dout_q;
    assign fdd_ack   = fdd_ack_q;
    assign misc_full = fifo_full;
    assign misc_ovf  = misc_ovf_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = (state_q == StIssue) && mem_wsel_q;
    assign mem_rd    = (state_q == StIssue) && !mem_wsel_q;
    assign err       = err_q;

endmodule
